// File: rtl/sokoban_pkg.sv
// Shared board geometry, pacing constants, sprite ids and sequencer state
// encoding for the Sokoban board renderer.
package sokoban_pkg;

  localparam int COLS       = 16;
  localparam int ROWS       = 8;
  localparam int TILE_SHIFT = 2;
  localparam int STROBE_CYC = 2;
  localparam int DRAW_CYC   = 20;

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int SPR_W  = 4;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;

  localparam logic [SPR_W-1:0] SPR_FLOOR    = 4'd0;
  localparam logic [SPR_W-1:0] SPR_WALL     = 4'd1;
  localparam logic [SPR_W-1:0] SPR_BOX      = 4'd2;
  localparam logic [SPR_W-1:0] SPR_GOAL     = 4'd3;
  localparam logic [SPR_W-1:0] SPR_PLAYER   = 4'd4;
  localparam logic [SPR_W-1:0] SPR_BOX_GOAL = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_STROBE = 3'd3,
    ST_WAIT   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/board_render_sequencer_if.sv
// Bundle between the render sequencer, the tile-request source, the tile RAM
// read port and the sprite_draw command inputs.
interface board_render_sequencer_if;
  import sokoban_pkg::*;

  logic              tile_req;
  logic [COL_W-1:0]  tile_col;
  logic [ROW_W-1:0]  tile_row;
  logic              tile_ack;
  logic [ADDR_W-1:0] board_addr;
  logic [SPR_W-1:0]  board_data;
  logic [X_W-1:0]    x_out;
  logic [Y_W-1:0]    y_out;
  logic [SPR_W-1:0]  sprite_id;
  logic              begin_draw;

  // master = sequencer side
  modport master (
    input  tile_req, tile_col, tile_row, board_data,
    output tile_ack, board_addr, x_out, y_out, sprite_id, begin_draw
  );

  modport slave (
    output tile_req, tile_col, tile_row, board_data,
    input  tile_ack, board_addr, x_out, y_out, sprite_id, begin_draw
  );

endinterface

// File: rtl/draw_pacer.sv
// Count-down timer covering the strobe and draw-wait phases of one draw
// command; loaded once per tile, flags strobe window and end of wait.
module draw_pacer #(
  parameter int STROBE_CYC = 2,
  parameter int DRAW_CYC   = 20
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_load,
  output logic o_strobe_active,
  output logic o_strobe_last,
  output logic o_wait_done
);

  localparam int TOTAL = STROBE_CYC + DRAW_CYC;
  localparam int CNT_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] WAIT_TOP = CNT_W'(DRAW_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  // Counts TOTAL-1 down to 0: the top STROBE_CYC values are the strobe window.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_strobe_active = r_run && (r_cnt >= WAIT_TOP);
  assign o_strobe_last   = r_run && (r_cnt == WAIT_TOP);
  assign o_wait_done     = r_run && (r_cnt == '0);

endmodule

// File: rtl/board_render_sequencer.sv
// Walks the board tile RAM and issues paced, active-low draw commands to
// sprite_draw: full-board raster passes or single-tile redraws.
module board_render_sequencer
  import sokoban_pkg::*;
(
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_start_full,
  output logic o_busy,
  output logic o_frame_done,
  board_render_sequencer_if.master bus
);

  seq_state_e r_state;
  seq_state_e w_state_next;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_full;
  logic             r_pending;
  logic             r_frame_done;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [SPR_W-1:0] r_sprite;

  logic w_strobe_active;
  logic w_strobe_last;
  logic w_wait_done;
  logic w_go_full;
  logic w_go_tile;
  logic w_go_next;
  logic w_last_tile;
  logic w_busy;
  logic w_begin_draw;
  logic w_tile_ack;

  assign w_last_tile = (r_col == COL_W'(COLS - 1)) && (r_row == ROW_W'(ROWS - 1));

  draw_pacer #(
    .STROBE_CYC (STROBE_CYC),
    .DRAW_CYC   (DRAW_CYC)
  ) u_pacer (
    .i_clk           (i_clk),
    .i_resetn        (i_resetn),
    .i_load          (r_state == ST_LATCH),
    .o_strobe_active (w_strobe_active),
    .o_strobe_last   (w_strobe_last),
    .o_wait_done     (w_wait_done)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_go_full    = 1'b0;
    w_go_tile    = 1'b0;
    w_go_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A full redraw wins; the tile requester keeps holding its request.
        if (i_start_full) begin
          w_state_next = ST_FETCH;
          w_go_full    = 1'b1;
        end else if (bus.tile_req) begin
          w_state_next = ST_FETCH;
          w_go_tile    = 1'b1;
        end
      end
      ST_FETCH:  w_state_next = ST_LATCH;
      ST_LATCH:  w_state_next = ST_STROBE;
      ST_STROBE: if (w_strobe_last) w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (w_wait_done) begin
          if (r_full) begin
            if (w_last_tile) begin
              w_state_next = ST_IDLE;
            end else begin
              w_state_next = ST_FETCH;
              w_go_next    = 1'b1;
            end
          end else if (r_pending || i_start_full) begin
            w_state_next = ST_FETCH;
            w_go_full    = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state != ST_IDLE);
    w_begin_draw = !((r_state == ST_STROBE) && w_strobe_active);
    w_tile_ack   = (r_state == ST_IDLE) && bus.tile_req && !i_start_full;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_col        <= '0;
      r_row        <= '0;
      r_full       <= 1'b0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_sprite     <= '0;
    end else begin
      r_frame_done <= (r_state == ST_WAIT) && w_wait_done && r_full && w_last_tile;

      if (w_go_full) begin
        r_col     <= '0;
        r_row     <= '0;
        r_full    <= 1'b1;
        r_pending <= 1'b0;
      end else if (w_go_tile) begin
        r_col  <= bus.tile_col;
        r_row  <= bus.tile_row;
        r_full <= 1'b0;
      end else if (w_go_next) begin
        if (r_col == COL_W'(COLS - 1)) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end else if ((r_state == ST_WAIT) && (w_state_next == ST_IDLE)) begin
        r_full <= 1'b0;
      end

      // A full request during a single-tile draw is remembered, not dropped.
      if (i_start_full && (r_state != ST_IDLE) && !r_full && !w_go_full) begin
        r_pending <= 1'b1;
      end

      if (r_state == ST_LATCH) begin
        r_sprite <= bus.board_data;
        r_x      <= X_W'(r_col) << TILE_SHIFT;
        r_y      <= Y_W'(r_row) << TILE_SHIFT;
      end
    end
  end

  assign bus.board_addr = {r_row, r_col};
  assign bus.x_out      = r_x;
  assign bus.y_out      = r_y;
  assign bus.sprite_id  = r_sprite;
  assign bus.begin_draw = w_begin_draw;
  assign bus.tile_ack   = w_tile_ack;
  assign o_busy         = w_busy;
  assign o_frame_done   = r_frame_done;

endmodule
